// File: rtl/sumador_serial.sv
// Bit-serial adder/subtractor: one full adder iterated LSB-first, one bit per clock.
// Subtraction is A + ~B + 1, so cout=1 means "no borrow".
module sumador_fa (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ c;
  assign co = (x & y) | (x & c) | (y & c);
endmodule

module sumador_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] ra, rb, rs;
  logic [CW-1:0]    cnt;
  logic             carry, sum_bit, carry_nx, accept, last;

  sumador_fa u_fa (.x(ra[0]), .y(rb[0]), .c(carry), .s(sum_bit), .co(carry_nx));

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(WIDTH-1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs only move at the completion edge, so they stay stable through a following RUN.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      ra    <= a;
      rb    <= op_sub ? ~b : b;
      carry <= op_sub | cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      ra    <= ra >> 1;
      rb    <= rb >> 1;
      rs    <= {sum_bit, rs[WIDTH-1:1]};
      carry <= carry_nx;
      cnt   <= cnt + 1'b1;
      if (last) begin
        s    <= {sum_bit, rs[WIDTH-1:1]};
        cout <= carry_nx;
        ovf  <= carry ^ carry_nx;
      end
    end
endmodule

// File: tb/tb_sumador_serial.sv
// Scoreboard bench for sumador_serial: WIDTH=8 directed ops plus a WIDTH=2 exhaustive sweep.
module tb_sumador_serial;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, op_sub, cin;
  logic [7:0] a, b, s;
  logic       busy, done, cout, ovf;

  logic       start2, op_sub2, cin2;
  logic [1:0] a2, b2, s2;
  logic       busy2, done2, cout2, ovf2;

  logic fx, fy, fc, fs, fco;

  sumador_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf));

  sumador_serial #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op_sub(op_sub2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2));

  sumador_fa u_fa (.x(fx), .y(fy), .c(fc), .s(fs), .co(fco));

  typedef struct packed { logic [7:0] s; logic c; logic o; } res8_t;
  typedef struct packed { logic [1:0] s; logic c; logic o; } res2_t;
  res8_t q8[$];
  res2_t q2[$];

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop expected result whenever a done pulse is seen
  always @(negedge clk) begin
    if (done) begin
      if (q8.size() == 0) chk("spurious_done8", {31'b0, done}, 32'd0);
      else begin
        res8_t e;
        e = q8.pop_front();
        chk("s8", {24'b0, s}, {24'b0, e.s});
        chk("cout8", {31'b0, cout}, {31'b0, e.c});
        chk("ovf8", {31'b0, ovf}, {31'b0, e.o});
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) chk("spurious_done2", {31'b0, done2}, 32'd0);
      else begin
        res2_t e;
        e = q2.pop_front();
        chk("s2", {30'b0, s2}, {30'b0, e.s});
        chk("cout2", {31'b0, cout2}, {31'b0, e.c});
        chk("ovf2", {31'b0, ovf2}, {31'b0, e.o});
      end
    end
  end

  // Caller must be at a negedge; returns one negedge later with start dropped.
  task automatic go8(input logic sub, input logic [7:0] aa, input logic [7:0] bb, input logic ci,
                     input logic [7:0] es, input logic ec, input logic eo, input bit push);
    start = 1'b1; op_sub = sub; a = aa; b = bb; cin = ci;
    if (push) q8.push_back('{s: es, c: ec, o: eo});
    @(negedge clk);
    start = 1'b0; op_sub = ~sub; a = ~aa; b = ~bb; cin = ~ci;
  endtask

  task automatic wait_done8(output int cyc, output int bsy);
    cyc = 1;
    bsy = busy ? 1 : 0;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (!done && busy) bsy++;
    end
    if (!done) chk("done8_timeout", {31'b0, done}, 32'd1);
  endtask

  typedef struct { logic sub; logic [7:0] a, b; logic ci; logic [7:0] s; logic c, o; } vec_t;
  vec_t vecs[5];
  int cyc, bsy;

  initial begin
    vecs[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};

    rst_n = 1'b1; start = 0; op_sub = 0; a = 0; b = 0; cin = 0;
    start2 = 0; op_sub2 = 0; a2 = 0; b2 = 0; cin2 = 0;
    fx = 0; fy = 0; fc = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_s", {24'b0, s}, 0);
    chk("rst_cout", {31'b0, cout}, 0);
    chk("rst_ovf", {31'b0, ovf}, 0);

    // Full-adder truth table: {x,y,c} -> {co,s}
    for (int i = 0; i < 8; i++) begin
      logic [7:0] tbl_s, tbl_c;
      tbl_s = 8'b1001_0110;
      tbl_c = 8'b1110_1000;
      {fx, fy, fc} = 3'(i);
      #1;
      chk("fa_s", {31'b0, fs}, {31'b0, tbl_s[i]});
      chk("fa_co", {31'b0, fco}, {31'b0, tbl_c[i]});
    end

    // Release and start on the very first edge: 0x7F+0x01
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go8(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    wait_done8(cyc, bsy);
    chk("latency", cyc, 9);
    chk("busy_cycles", bsy, 8);

    foreach (vecs[i]) begin
      @(negedge clk);
      go8(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].c, vecs[i].o, 1'b1);
      wait_done8(cyc, bsy);
    end

    // Start during RUN is ignored; back-to-back start in DONE
    @(negedge clk);
    go8(1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    go8(1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_done8(cyc, bsy);
    go8(1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("b2b_busy", {31'b0, busy}, 1);
    chk("b2b_done", {31'b0, done}, 0);
    chk("b2b_s_held", {24'b0, s}, 32'h30);
    wait_done8(cyc, bsy);

    // Abort at RUN cycle 4: outputs clear without a clock edge
    @(negedge clk);
    go8(1'b0, 8'h55, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_s", {24'b0, s}, 0);
    chk("abort_cout", {31'b0, cout}, 0);
    chk("abort_ovf", {31'b0, ovf}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    go8(1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    chk("post_rst_accept", {31'b0, busy}, 1);
    wait_done8(cyc, bsy);
    repeat (12) @(negedge clk);

    // WIDTH=2 exhaustive against an arithmetic model
    for (int sub = 0; sub < 2; sub++)
      for (int ai = 0; ai < 4; ai++)
        for (int bi = 0; bi < 4; bi++)
          for (int ci = 0; ci < 2; ci++) begin
            logic [1:0] be, av;
            logic [2:0] sm;
            int n;
            av = 2'(ai);
            be = (sub != 0) ? ~2'(bi) : 2'(bi);
            sm = {1'b0, av} + {1'b0, be} + ((sub != 0) ? 3'd1 : 3'(ci));
            q2.push_back('{s: sm[1:0], c: sm[2], o: (av[1] == be[1]) && (sm[1] != av[1])});
            @(negedge clk);
            start2 = 1'b1; op_sub2 = sub[0]; a2 = 2'(ai); b2 = 2'(bi); cin2 = ci[0];
            @(negedge clk);
            start2 = 1'b0;
            n = 0;
            while (!done2 && n < 10) begin
              @(negedge clk);
              n++;
            end
            if (!done2) chk("done2_timeout", {31'b0, done2}, 32'd1);
          end

    @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
